// File: rtl/aap_mem_pkg.sv
// Shared definitions for the data memory access unit.
//   Lanes          : number of byte lanes on the data memory (4)
//   RdTopDefault   : default highest legal load byte address
//   WrTopDefault   : default highest legal store byte address
//   size_e         : request size encodings
//   state_e        : access FSM states
//   size_bytes()   : number of bytes moved for a size code (0 for illegal)
package aap_mem_pkg;

  localparam int unsigned Lanes        = 4;
  localparam int unsigned RdTopDefault = 128;
  localparam int unsigned WrTopDefault = 63;

  typedef enum logic [1:0] {
    SizeByte    = 2'd0,
    SizeHalf    = 2'd1,
    SizeWord    = 2'd2,
    SizeIllegal = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SizeByte: n = 3'd1;
      SizeHalf: n = 3'd2;
      SizeWord: n = 3'd4;
      default:  n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_lane_map.sv
// Combinational lane mapper for a latched memory request.
// Inputs : write (1 = store), size (byte/half/word/illegal), addr (lowest byte
//          address), wdata (little-endian store data).
// Outputs: legal (request is in range and well sized), lane_used (per-lane
//          participation, already gated by legal), lane_addr / lane_data
//          (per-lane byte address and store byte, zero on unused lanes).
module mem_lane_map
  import aap_mem_pkg::*;
#(
  parameter int unsigned RD_TOP = RdTopDefault,
  parameter int unsigned WR_TOP = WrTopDefault
) (
  input  logic                  write,
  input  logic [1:0]            size,
  input  logic [8:0]            addr,
  input  logic [31:0]           wdata,
  output logic                  legal,
  output logic [Lanes-1:0]      lane_used,
  output logic [Lanes-1:0][8:0] lane_addr,
  output logic [Lanes-1:0][7:0] lane_data
);

  logic [2:0] bytes;
  logic [9:0] last_addr;
  logic [9:0] top_addr;

  always_comb begin
    bytes     = size_bytes(size);
    // 10-bit sum so a request running past 511 cannot wrap back into range.
    last_addr = {1'b0, addr} + {7'd0, bytes} - 10'd1;
    top_addr  = write ? 10'(WR_TOP) : 10'(RD_TOP);
    legal     = (size != SizeIllegal) && (last_addr <= top_addr);

    for (int unsigned i = 0; i < Lanes; i++) begin
      lane_used[i] = legal && (i < 32'(bytes));
      lane_addr[i] = lane_used[i] ? addr + 9'(i) : 9'd0;
      lane_data[i] = lane_used[i] ? wdata[8*i +: 8] : 8'd0;
    end
  end

endmodule

// File: rtl/data_mem_access.sv
// Data memory access unit: accepts one load/store request at a time, drives
// the four byte lanes of the data memory for a single cycle, then holds a
// response until the consumer takes it.
// Ports:
//   clock, reset                 : clock and synchronous active-high reset
//   req_valid/req_ready          : request handshake
//   req_write/size/addr/wdata    : request fields
//   resp_valid/resp_ready        : response handshake
//   resp_rdata/resp_error        : zero-extended load data / illegal flag
//   mem_rdN, mem_rdN_out         : per-lane read address and read data
//   mem_wrN, _data, _enable      : per-lane write address, data and strobe
module data_mem_access
  import aap_mem_pkg::*;
#(
  parameter int unsigned RD_TOP = RdTopDefault,
  parameter int unsigned WR_TOP = WrTopDefault
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [8:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [8:0]  mem_rd1,
  output logic [8:0]  mem_rd2,
  output logic [8:0]  mem_rd3,
  output logic [8:0]  mem_rd4,
  input  logic [7:0]  mem_rd1_out,
  input  logic [7:0]  mem_rd2_out,
  input  logic [7:0]  mem_rd3_out,
  input  logic [7:0]  mem_rd4_out,
  output logic [5:0]  mem_wr1,
  output logic [5:0]  mem_wr2,
  output logic [5:0]  mem_wr3,
  output logic [5:0]  mem_wr4,
  output logic [7:0]  mem_wr1_data,
  output logic [7:0]  mem_wr2_data,
  output logic [7:0]  mem_wr3_data,
  output logic [7:0]  mem_wr4_data,
  output logic        mem_wr1_enable,
  output logic        mem_wr2_enable,
  output logic        mem_wr3_enable,
  output logic        mem_wr4_enable
);

  state_e state_q, state_d;

  logic        write_q;
  logic [1:0]  size_q;
  logic [8:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        error_q;

  logic                  legal;
  logic [Lanes-1:0]      lane_used;
  logic [Lanes-1:0][8:0] lane_addr;
  logic [Lanes-1:0][7:0] lane_data;

  logic        handshake;
  logic [31:0] load_data;

  mem_lane_map #(
    .RD_TOP(RD_TOP),
    .WR_TOP(WR_TOP)
  ) u_lane_map (
    .write    (write_q),
    .size     (size_q),
    .addr     (addr_q),
    .wdata    (wdata_q),
    .legal    (legal),
    .lane_used(lane_used),
    .lane_addr(lane_addr),
    .lane_data(lane_data)
  );

  assign handshake = req_valid && (state_q == StIdle);

  // Unused lanes read back as zero so narrow loads come out zero-extended.
  always_comb begin
    load_data = {lane_used[3] ? mem_rd4_out : 8'h00,
                 lane_used[2] ? mem_rd3_out : 8'h00,
                 lane_used[1] ? mem_rd2_out : 8'h00,
                 lane_used[0] ? mem_rd1_out : 8'h00};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 9'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        write_q <= req_write;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == StAccess) begin
        error_q <= !legal;
        rdata_q <= (legal && !write_q) ? load_data : 32'd0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_valid) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   if (resp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Every output is gated by reset so it reads as idle in the reset cycle
  // itself, even if the FSM is still sitting in ACCESS.
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = 32'd0;
    resp_error     = 1'b0;
    mem_rd1        = 9'd0;
    mem_rd2        = 9'd0;
    mem_rd3        = 9'd0;
    mem_rd4        = 9'd0;
    mem_wr1        = 6'd0;
    mem_wr2        = 6'd0;
    mem_wr3        = 6'd0;
    mem_wr4        = 6'd0;
    mem_wr1_data   = 8'd0;
    mem_wr2_data   = 8'd0;
    mem_wr3_data   = 8'd0;
    mem_wr4_data   = 8'd0;
    mem_wr1_enable = 1'b0;
    mem_wr2_enable = 1'b0;
    mem_wr3_enable = 1'b0;
    mem_wr4_enable = 1'b0;

    if (!reset) begin
      req_ready = (state_q == StIdle);
      if (state_q == StResp) begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_error = error_q;
      end
      if (state_q == StAccess) begin
        mem_rd1        = lane_addr[0];
        mem_rd2        = lane_addr[1];
        mem_rd3        = lane_addr[2];
        mem_rd4        = lane_addr[3];
        // Store lanes never exceed WR_TOP, so the low six bits are the address.
        mem_wr1        = lane_addr[0][5:0];
        mem_wr2        = lane_addr[1][5:0];
        mem_wr3        = lane_addr[2][5:0];
        mem_wr4        = lane_addr[3][5:0];
        mem_wr1_data   = lane_data[0];
        mem_wr2_data   = lane_data[1];
        mem_wr3_data   = lane_data[2];
        mem_wr4_data   = lane_data[3];
        mem_wr1_enable = write_q && lane_used[0];
        mem_wr2_enable = write_q && lane_used[1];
        mem_wr3_enable = write_q && lane_used[2];
        mem_wr4_enable = write_q && lane_used[3];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_access.sv
// Directed bench for data_mem_access with a byte-wide memory model on the lanes.
module tb_data_mem_access;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [8:0]  mem_rd1, mem_rd2, mem_rd3, mem_rd4;
  logic [7:0]  mem_rd1_out, mem_rd2_out, mem_rd3_out, mem_rd4_out;
  logic [5:0]  mem_wr1, mem_wr2, mem_wr3, mem_wr4;
  logic [7:0]  mem_wr1_data, mem_wr2_data, mem_wr3_data, mem_wr4_data;
  logic        mem_wr1_enable, mem_wr2_enable, mem_wr3_enable, mem_wr4_enable;

  int errors = 0;
  int checks = 0;

  data_mem_access dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_error    (resp_error),
    .mem_rd1       (mem_rd1),
    .mem_rd2       (mem_rd2),
    .mem_rd3       (mem_rd3),
    .mem_rd4       (mem_rd4),
    .mem_rd1_out   (mem_rd1_out),
    .mem_rd2_out   (mem_rd2_out),
    .mem_rd3_out   (mem_rd3_out),
    .mem_rd4_out   (mem_rd4_out),
    .mem_wr1       (mem_wr1),
    .mem_wr2       (mem_wr2),
    .mem_wr3       (mem_wr3),
    .mem_wr4       (mem_wr4),
    .mem_wr1_data  (mem_wr1_data),
    .mem_wr2_data  (mem_wr2_data),
    .mem_wr3_data  (mem_wr3_data),
    .mem_wr4_data  (mem_wr4_data),
    .mem_wr1_enable(mem_wr1_enable),
    .mem_wr2_enable(mem_wr2_enable),
    .mem_wr3_enable(mem_wr3_enable),
    .mem_wr4_enable(mem_wr4_enable)
  );

  always #5 clock = ~clock;

  // Memory model: cleared while reset is high, written on enabled lanes.
  logic [7:0] mem [0:511];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
    end else begin
      if (mem_wr1_enable) mem[{3'b000, mem_wr1}] <= mem_wr1_data;
      if (mem_wr2_enable) mem[{3'b000, mem_wr2}] <= mem_wr2_data;
      if (mem_wr3_enable) mem[{3'b000, mem_wr3}] <= mem_wr3_data;
      if (mem_wr4_enable) mem[{3'b000, mem_wr4}] <= mem_wr4_data;
    end
  end
  assign mem_rd1_out = mem[mem_rd1];
  assign mem_rd2_out = mem[mem_rd2];
  assign mem_rd3_out = mem[mem_rd3];
  assign mem_rd4_out = mem[mem_rd4];

  logic [23:0] wr_addrs;
  logic [31:0] wr_data;
  logic [3:0]  wr_en;
  assign wr_addrs = {mem_wr4, mem_wr3, mem_wr2, mem_wr1};
  assign wr_data  = {mem_wr4_data, mem_wr3_data, mem_wr2_data, mem_wr1_data};
  assign wr_en    = {mem_wr4_enable, mem_wr3_enable, mem_wr2_enable, mem_wr1_enable};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for req_ready, then performs one handshake; returns in ACCESS.
  task automatic issue(input logic w, input logic [1:0] s, input logic [8:0] a,
                       input logic [31:0] d);
    int n = 0;
    while (!req_ready && n < 10) begin
      tick();
      n++;
    end
    if (!req_ready) check_val("req_ready_timeout", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_size  = s;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  // Full transaction with resp_ready=1, checking the response contents.
  task automatic run_req(input string tag, input logic w, input logic [1:0] s,
                         input logic [8:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rdata, input logic exp_err);
    issue(w, s, a, d);
    tick();
    check_val({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    check_val({tag, "_rdata"}, resp_rdata, exp_rdata);
    check_val({tag, "_error"}, {31'd0, resp_error}, {31'd0, exp_err});
    tick();
  endtask

  initial begin
    int hs[$];
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'd0;
    req_addr   = 9'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;
    tick();
    tick();
    check_val("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("rst_wr_en", {28'd0, wr_en}, 32'd0);
    reset = 1'b0;
    #1;
    check_val("rel_req_ready", {31'd0, req_ready}, 32'd1);

    // Word store at 0x10.
    issue(1'b1, 2'd2, 9'h010, 32'hAABBCCDD);
    check_val("stw_addrs", {8'd0, wr_addrs}, {8'd0, 6'h13, 6'h12, 6'h11, 6'h10});
    check_val("stw_data", wr_data, 32'hAABBCCDD);
    check_val("stw_en", {28'd0, wr_en}, 32'hF);
    check_val("stw_acc_valid", {31'd0, resp_valid}, 32'd0);
    check_val("stw_acc_ready", {31'd0, req_ready}, 32'd0);
    tick();
    check_val("stw_en_off", {28'd0, wr_en}, 32'd0);
    check_val("stw_valid", {31'd0, resp_valid}, 32'd1);
    check_val("stw_error", {31'd0, resp_error}, 32'd0);
    check_val("stw_rdata", resp_rdata, 32'd0);
    tick();

    // Half load at 0x11 reads back the middle two stored bytes.
    issue(1'b0, 2'd1, 9'h011, 32'd0);
    check_val("ldh_rd1", {23'd0, mem_rd1}, 32'h11);
    check_val("ldh_rd2", {23'd0, mem_rd2}, 32'h12);
    check_val("ldh_rd34", {14'd0, mem_rd3, mem_rd4}, 32'd0);
    check_val("ldh_en", {28'd0, wr_en}, 32'd0);
    tick();
    check_val("ldh_valid", {31'd0, resp_valid}, 32'd1);
    check_val("ldh_rdata", resp_rdata, 32'h0000BBCC);
    check_val("ldh_error", {31'd0, resp_error}, 32'd0);
    tick();

    // Misaligned accesses.
    run_req("mis_stw", 1'b1, 2'd2, 9'h021, 32'h11223344, 32'd0, 1'b0);
    run_req("mis_ldw", 1'b0, 2'd2, 9'h021, 32'd0, 32'h11223344, 1'b0);
    run_req("mis_ldb", 1'b0, 2'd0, 9'h023, 32'd0, 32'h00000022, 1'b0);

    // Store boundary at WR_TOP.
    issue(1'b1, 2'd0, 9'd63, 32'h0000005A);
    check_val("stb63_en", {28'd0, wr_en}, 32'h1);
    check_val("stb63_addrs", {8'd0, wr_addrs}, {8'd0, 18'd0, 6'h3F});
    check_val("stb63_data", wr_data, 32'h0000005A);
    tick();
    check_val("stb63_error", {31'd0, resp_error}, 32'd0);
    tick();
    issue(1'b1, 2'd1, 9'd63, 32'h00001234);
    check_val("sth63_en", {28'd0, wr_en}, 32'd0);
    tick();
    check_val("sth63_error", {31'd0, resp_error}, 32'd1);
    check_val("sth63_rdata", resp_rdata, 32'd0);
    tick();
    run_req("stw60", 1'b1, 2'd2, 9'd60, 32'hCAFEF00D, 32'd0, 1'b0);
    run_req("ldw60", 1'b0, 2'd2, 9'd60, 32'd0, 32'hCAFEF00D, 1'b0);
    run_req("stw61", 1'b1, 2'd2, 9'd61, 32'hFFFFFFFF, 32'd0, 1'b1);
    run_req("ldw60b", 1'b0, 2'd2, 9'd60, 32'd0, 32'hCAFEF00D, 1'b0);

    // Load boundary at RD_TOP and illegal size.
    run_req("ldh128", 1'b0, 2'd1, 9'd128, 32'd0, 32'd0, 1'b1);
    run_req("ldb128", 1'b0, 2'd0, 9'd128, 32'd0, 32'd0, 1'b0);
    run_req("ldh127", 1'b0, 2'd1, 9'd127, 32'd0, 32'd0, 1'b0);
    run_req("ldw126", 1'b0, 2'd2, 9'd126, 32'd0, 32'd0, 1'b1);
    run_req("ldsz3", 1'b0, 2'd3, 9'd0, 32'd0, 32'd0, 1'b1);

    // Response back-pressure: hold resp_ready low while a new request waits.
    issue(1'b0, 2'd0, 9'h010, 32'd0);
    resp_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check_val("hold_valid", {31'd0, resp_valid}, 32'd1);
      check_val("hold_rdata", resp_rdata, 32'h000000DD);
      check_val("hold_ready", {31'd0, req_ready}, 32'd0);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_size  = 2'd2;
      req_addr  = 9'd0;
      req_wdata = 32'hFFFFFFFF;
      tick();
    end
    check_val("hold_valid_end", {31'd0, resp_valid}, 32'd1);
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    tick();
    check_val("hold_idle_ready", {31'd0, req_ready}, 32'd1);
    check_val("hold_idle_valid", {31'd0, resp_valid}, 32'd0);
    check_val("hold_no_store", {24'd0, mem[0]}, 32'd0);

    // Reset during the ACCESS cycle of a word store.
    issue(1'b1, 2'd2, 9'h030, 32'h01020304);
    reset = 1'b1;
    #1;
    check_val("rstacc_en", {28'd0, wr_en}, 32'd0);
    check_val("rstacc_addrs", {8'd0, wr_addrs}, 32'd0);
    check_val("rstacc_ready", {31'd0, req_ready}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_val("rstrel_ready", {31'd0, req_ready}, 32'd1);
    check_val("rstrel_valid", {31'd0, resp_valid}, 32'd0);
    tick();
    check_val("rstrel_valid2", {31'd0, resp_valid}, 32'd0);

    // Back-to-back requests with resp_ready tied high.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'd0;
    req_addr  = 9'h010;
    for (int c = 0; c < 12; c++) begin
      if (req_valid && req_ready) hs.push_back(c);
      tick();
    end
    req_valid = 1'b0;
    check_val("b2b_count", hs.size(), 32'd4);
    if (hs.size() >= 3) begin
      check_val("b2b_gap1", hs[1] - hs[0], 32'd3);
      check_val("b2b_gap2", hs[2] - hs[1], 32'd3);
    end
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
